ocra1_iface: RTL and testbench
==============================

OCRA1_IFACE -- requirements
Module: ocra1_iface

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; clock port `clk`, reset port `rst`.
REQ-002 Parameter: SCLK_HALF, default 1, clk cycles per oc1_clk_o half-period (legal range >=1).
REQ-003 Parameter: LDAC_CYCLES, default 2, clk cycles that oc1_ldacn_o is held low.
REQ-004 clk  input  1  system clock; all logic uses its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 datax_i, datay_i, dataz_i, dataz2_i  input  24 each  DAC SPI words for the x/y/z/z2 channels.
REQ-007 valid_i  input  1  one-cycle strobe; the four data words are valid in the same cycle.
REQ-008 busy_o  output  1  high while a transfer or LDAC pulse is in progress.
REQ-009 oc1_clk_o  output  1  shared serial clock; idles high.
REQ-010 oc1_syncn_o  output  1  active-low frame/chip-select shared by all four DACs.
REQ-011 oc1_ldacn_o  output  1  active-low load-DAC strobe.
REQ-012 oc1_sdox_o, oc1_sdoy_o, oc1_sdoz_o, oc1_sdoz2_o  output  1 each  serial data lines, MSB first.

Function
REQ-013 SHALL have four states: IDLE, SHIFT, GAP and LDAC.
REQ-014 In IDLE with valid_i=1, it SHALL latch all four words into 24-bit shift registers and enter SHIFT on the next cycle.
REQ-015 When valid_i is high while busy_o=1, it SHALL ignore valid_i; the in-progress transfer SHALL NOT be disturbed.
REQ-016 busy_o SHALL rise in the cycle after valid_i is accepted.
REQ-017 busy_o SHALL stay high through SHIFT, GAP and LDAC.
REQ-018 busy_o SHALL fall on entry to IDLE, so a new valid_i is accepted in that same cycle.
REQ-019 SHIFT: oc1_syncn_o SHALL be 0 for exactly 24 oc1_clk_o periods (48*SCLK_HALF clk cycles).
REQ-020 SHIFT: in each period, oc1_clk_o SHALL be high for the first half and low for the second half.
REQ-021 SHIFT: on each oc1_clk_o rising edge, a new bit SHALL be driven on all four sdo lines simultaneously.
REQ-022 The first bit (bit 23) SHALL be valid when oc1_syncn_o falls; the DAC samples on the oc1_clk_o falling edge.
REQ-023 After the 24th falling edge, oc1_clk_o SHALL return high, oc1_syncn_o SHALL return to 1, and the state SHALL become GAP.
REQ-024 GAP SHALL last 2 clk cycles, with syncn=1 and ldacn=1.
REQ-025 LDAC: oc1_ldacn_o SHALL be 0 for LDAC_CYCLES clk cycles, then return to 1 and the state SHALL become IDLE.
REQ-026 Sdo lines SHALL be 0 outside SHIFT.
REQ-027 Words SHALL be transmitted unmodified (no format conversion); total transfer SHALL be 1+48+2+2 = 53 clk cycles at defaults.
REQ-028 Reset asserted mid-transfer SHALL abort immediately: outputs go to their reset values and the state returns to IDLE; no LDAC pulse.

Reset
REQ-029 During reset: oc1_clk_o=1, oc1_syncn_o=1, oc1_ldacn_o=1, all sdo lines=0, busy_o=0, state=IDLE, shift registers=0, counters=0.

Structure
REQ-030 A shared package SHALL hold WORD_W=24, DAC_W=18, the state enumeration, and the AD5781 field positions (R/W bit 23, address [22:20], data [19:2]).
REQ-031 One sub-module, ocra1_shreg (24-bit load/shift-left register with MSB output), SHALL be instantiated once per channel.
REQ-032 ocra1_model SHALL be a non-synthesised bench model of the board; its inputs are clk (= oc1_clk_o), syncn, ldacn, sdox/y/z/z2, and its outputs are voutx/y/z/z2, each 18 bits.
REQ-033 Model shifting: ocra1_model SHALL shift one bit per sdo line on each clk falling edge while syncn=0.
REQ-034 Model word capture: on syncn rising after exactly 24 bits with bit23=0 and address=001, ocra1_model SHALL store bits [19:2].
REQ-035 Model output update: when ldacn=0, ocra1_model SHALL copy the stored values to vout; all vout SHALL be 0 initially.

Verification
REQ-036 Send words (1,2,3,4) after reset: the 24 sdo bits SHALL equal 1,2,3,4 MSB first; busy_o SHALL be high for 52 cycles; the vout values SHALL stay 0 (address 000).
REQ-037 Send 0x100004/0x100008/0x10000C/0x100010: after the ldacn pulse, voutx/y/z/z2 SHALL be 1/2/3/4.
REQ-038 A second valid_i 10 cycles into the transfer SHALL be ignored; exactly one syncn frame SHALL occur and the data SHALL be unchanged.
REQ-039 Back-to-back sends: a valid_i in the cycle busy_o falls SHALL be accepted; two frames SHALL occur separated by the LDAC pulse.
REQ-040 Reset asserted in cycle 20 of SHIFT: syncn=1, sclk=1, busy_o=0 immediately; no ldacn pulse; vout values unchanged.
REQ-041 With SCLK_HALF=3: the syncn low time SHALL be 144 cycles, and sclk high and low times SHALL each be 3 cycles.

Source files
------------

// File: rtl/ocra1_pkg.sv
// Shared types and constants for the OCRA1 four-channel AD5781 DAC interface.
// Field positions describe the 24-bit AD5781 SPI word.
package ocra1_pkg;

    localparam int unsigned WORD_W  = 24;
    localparam int unsigned DAC_W   = 18;

    localparam int unsigned RW_BIT  = 23;
    localparam int unsigned ADDR_HI = 22;
    localparam int unsigned ADDR_LO = 20;
    localparam int unsigned DATA_HI = 19;
    localparam int unsigned DATA_LO = 2;

    localparam logic [ADDR_HI-ADDR_LO:0] ADDR_DAC = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_LDAC
    } state_t;

    typedef struct packed {
        logic                       rw;
        logic [ADDR_HI-ADDR_LO:0]   addr;
        logic [DAC_W-1:0]           data;
        logic [DATA_LO-1:0]         rsvd;
    } ad5781_word_t;

    // Builds a DAC-register write word for an 18-bit output code.
    function automatic logic [WORD_W-1:0] dac_write_word(input logic [DAC_W-1:0] value);
        logic [WORD_W-1:0] w;
        w                   = '0;
        w[RW_BIT]           = 1'b0;
        w[ADDR_HI:ADDR_LO]  = ADDR_DAC;
        w[DATA_HI:DATA_LO]  = value;
        return w;
    endfunction

endpackage

// File: rtl/ocra1_shreg.sv
// Per-channel 24-bit load / shift-left register; MSB drives the serial data line.
// Shifting in zeros leaves the line low once the whole word has gone out.
module ocra1_shreg
    import ocra1_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic              msb
);

    logic [WORD_W-1:0] sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= din;
        end else if (shift) begin
            sr_q <= {sr_q[WORD_W-2:0], 1'b0};
        end
    end

    assign msb = sr_q[WORD_W-1];

endmodule

// File: rtl/ocra1_iface.sv
// OCRA1 board interface: shifts four 24-bit AD5781 words out in parallel on a
// shared serial clock/frame, then pulses LDAC to update all four DACs together.
module ocra1_iface
    import ocra1_pkg::*;
#(
    parameter int unsigned SCLK_HALF   = 1,
    parameter int unsigned LDAC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] datax_i,
    input  logic [WORD_W-1:0] datay_i,
    input  logic [WORD_W-1:0] dataz_i,
    input  logic [WORD_W-1:0] dataz2_i,
    input  logic              valid_i,
    output logic              busy_o,
    output logic              oc1_clk_o,
    output logic              oc1_syncn_o,
    output logic              oc1_ldacn_o,
    output logic              oc1_sdox_o,
    output logic              oc1_sdoy_o,
    output logic              oc1_sdoz_o,
    output logic              oc1_sdoz2_o
);

    localparam int unsigned HALF_W     = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int unsigned PHASES     = 2 * WORD_W;
    localparam int unsigned PHASE_W    = $clog2(PHASES);
    localparam int unsigned GAP_CYCLES = 2;
    localparam int unsigned CNT_MAX    = (LDAC_CYCLES > GAP_CYCLES) ? LDAC_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t               state_q, state_d;
    logic [HALF_W-1:0]    half_q, half_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sclk_q, sclk_d;
    logic                 syncn_q, syncn_d;
    logic                 ldacn_q, ldacn_d;
    logic                 busy_q, busy_d;
    logic                 load_c;
    logic                 shift_c;

    logic [3:0][WORD_W-1:0] words;
    logic [3:0]             sdo;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            half_q  <= '0;
            phase_q <= '0;
            cnt_q   <= '0;
            sclk_q  <= 1'b1;
            syncn_q <= 1'b1;
            ldacn_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            sclk_q  <= sclk_d;
            syncn_q <= syncn_d;
            ldacn_q <= ldacn_d;
            busy_q  <= busy_d;
        end
    end

    // Next state; output values describe the cycle being entered.
    // Even phases are the high half of a serial clock period, odd phases the low half.
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        sclk_d  = 1'b1;
        syncn_d = 1'b1;
        ldacn_d = 1'b1;
        busy_d  = 1'b1;
        load_c  = 1'b0;
        shift_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (valid_i) begin
                    load_c  = 1'b1;
                    state_d = ST_SHIFT;
                    half_d  = '0;
                    phase_d = '0;
                    syncn_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            ST_SHIFT: begin
                syncn_d = 1'b0;
                sclk_d  = sclk_q;
                if (half_q == HALF_W'(SCLK_HALF - 1)) begin
                    half_d  = '0;
                    // Next bit is presented as the serial clock rises again
                    shift_c = phase_q[0];
                    if (phase_q == PHASE_W'(PHASES - 1)) begin
                        state_d = ST_GAP;
                        phase_d = '0;
                        cnt_d   = '0;
                        syncn_d = 1'b1;
                        sclk_d  = 1'b1;
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                        sclk_d  = phase_q[0];
                    end
                end else begin
                    half_d = half_q + HALF_W'(1);
                end
            end

            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_LDAC;
                    cnt_d   = '0;
                    ldacn_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_LDAC: begin
                ldacn_d = 1'b0;
                if (cnt_q == CNT_W'(LDAC_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ldacn_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign words = {dataz2_i, dataz_i, datay_i, datax_i};

    for (genvar ch = 0; ch < 4; ch++) begin : g_ch
        ocra1_shreg u_shreg (
            .clk   (clk),
            .rst   (rst),
            .load  (load_c),
            .shift (shift_c),
            .din   (words[ch]),
            .msb   (sdo[ch])
        );
    end

    assign busy_o      = busy_q;
    assign oc1_clk_o   = sclk_q;
    assign oc1_syncn_o = syncn_q;
    assign oc1_ldacn_o = ldacn_q;
    assign oc1_sdox_o  = sdo[0];
    assign oc1_sdoy_o  = sdo[1];
    assign oc1_sdoz_o  = sdo[2];
    assign oc1_sdoz2_o = sdo[3];

endmodule

// File: tb/tb_ocra1_iface.sv
// Bench for ocra1_iface: board model of four AD5781 DACs plus table, random and
// multi-cycle corner-case sequences.

// Board model: shifts on falling serial clock, captures DAC writes at frame end,
// transfers captured codes to the outputs while LDAC is low.
module ocra1_model (
    input  logic        clk,
    input  logic        syncn,
    input  logic        ldacn,
    input  logic        sdox,
    input  logic        sdoy,
    input  logic        sdoz,
    input  logic        sdoz2,
    output logic [17:0] voutx,
    output logic [17:0] vouty,
    output logic [17:0] voutz,
    output logic [17:0] voutz2
);
    logic [3:0][23:0] sr   = '0;
    logic [3:0][17:0] held = '0;
    logic [3:0][17:0] vout = '0;
    int               cnt  = 0;

    always @(negedge clk or posedge syncn) begin
        if (syncn) begin
            if (cnt == 24) begin
                for (int c = 0; c < 4; c++) begin
                    if (sr[c][23] == 1'b0 && sr[c][22:20] == 3'b001) held[c] <= sr[c][19:2];
                end
            end
            cnt <= 0;
        end else begin
            sr[0] <= {sr[0][22:0], sdox};
            sr[1] <= {sr[1][22:0], sdoy};
            sr[2] <= {sr[2][22:0], sdoz};
            sr[3] <= {sr[3][22:0], sdoz2};
            cnt   <= cnt + 1;
        end
    end

    always @(ldacn or held) begin
        if (!ldacn) vout = held;
    end

    assign voutx  = vout[0];
    assign vouty  = vout[1];
    assign voutz  = vout[2];
    assign voutz2 = vout[3];
endmodule

module tb_ocra1_iface;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        valid3 = 1'b0;
    logic [23:0] dx = '0, dy = '0, dz = '0, dz2 = '0;

    logic busy, sclk, syncn, ldacn, sx, sy, sz, sz2;
    logic busy3, sclk3, syncn3, ldacn3, sx3, sy3, sz3, sz23;
    logic [17:0] vx, vy, vz, vz2;
    logic [3:0][17:0] vv;

    always #5 clk = ~clk;

    ocra1_iface u_dut (
        .clk(clk), .rst(rst),
        .datax_i(dx), .datay_i(dy), .dataz_i(dz), .dataz2_i(dz2),
        .valid_i(valid), .busy_o(busy),
        .oc1_clk_o(sclk), .oc1_syncn_o(syncn), .oc1_ldacn_o(ldacn),
        .oc1_sdox_o(sx), .oc1_sdoy_o(sy), .oc1_sdoz_o(sz), .oc1_sdoz2_o(sz2)
    );

    ocra1_iface #(.SCLK_HALF(3), .LDAC_CYCLES(2)) u_dut3 (
        .clk(clk), .rst(rst),
        .datax_i(dx), .datay_i(dy), .dataz_i(dz), .dataz2_i(dz2),
        .valid_i(valid3), .busy_o(busy3),
        .oc1_clk_o(sclk3), .oc1_syncn_o(syncn3), .oc1_ldacn_o(ldacn3),
        .oc1_sdox_o(sx3), .oc1_sdoy_o(sy3), .oc1_sdoz_o(sz3), .oc1_sdoz2_o(sz23)
    );

    ocra1_model u_model (
        .clk(sclk), .syncn(syncn), .ldacn(ldacn),
        .sdox(sx), .sdoy(sy), .sdoz(sz), .sdoz2(sz2),
        .voutx(vx), .vouty(vy), .voutz(vz), .voutz2(vz2)
    );

    assign vv = {vz2, vz, vy, vx};

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference rule: a channel updates only on a write (R/W=0) to the DAC register (addr 001)
    function automatic logic [17:0] ref_next(input logic [23:0] w, input logic [17:0] old);
        return (w[23:20] == 4'h1) ? w[19:2] : old;
    endfunction

    // Results of the last run()
    logic [1:0][3:0][23:0] cap;
    int frames, busy_cyc, syncn_cyc, ldac_pulses, ldac_cyc, gap_cyc, ldac1_end, frame2_start;
    bit timed_out;

    // Sends words a; optionally raises valid with words b at cycle 'inject' or
    // back-to-back in the first idle cycle ('chain'); watches the bus until idle.
    task automatic run(input logic [3:0][23:0] a, input logic [3:0][23:0] b,
                       input int inject, input bit chain);
        bit   done = 0, chained = 0;
        logic p_sync = 1'b1, p_sclk = 1'b1, p_ldac = 1'b1;
        int   cyc = 0;
        cap = '0; frames = 0; busy_cyc = 0; syncn_cyc = 0; ldac_pulses = 0;
        ldac_cyc = 0; gap_cyc = 0; ldac1_end = -1; frame2_start = -1; timed_out = 0;
        @(negedge clk);
        {dz2, dz, dy, dx} = a;
        valid = 1'b1;
        @(negedge clk);
        while (!done) begin
            valid = 1'b0;
            if (!syncn && p_sync) begin
                frames++;
                if (frames == 2) frame2_start = cyc;
            end
            if (p_sclk && !sclk && !syncn && frames >= 1 && frames <= 2) begin
                cap[frames-1][0] = {cap[frames-1][0][22:0], sx};
                cap[frames-1][1] = {cap[frames-1][1][22:0], sy};
                cap[frames-1][2] = {cap[frames-1][2][22:0], sz};
                cap[frames-1][3] = {cap[frames-1][3][22:0], sz2};
            end
            if (busy)   busy_cyc++;
            if (!syncn) syncn_cyc++;
            if (!ldacn) ldac_cyc++;
            if (!ldacn && p_ldac) ldac_pulses++;
            if (ldacn && !p_ldac && ldac1_end < 0) ldac1_end = cyc;
            if (cyc == inject) begin
                {dz2, dz, dy, dx} = b;
                valid = 1'b1;
            end
            if (!busy) begin
                if (chain && !chained) begin
                    chained = 1;
                    gap_cyc++;
                    {dz2, dz, dy, dx} = b;
                    valid = 1'b1;
                end else begin
                    done = 1;
                end
            end
            p_sync = syncn; p_sclk = sclk; p_ldac = ldacn;
            cyc++;
            if (cyc > 300) begin
                timed_out = 1;
                done = 1;
            end
            if (!done) @(negedge clk);
        end
        valid = 1'b0;
    endtask

    typedef struct {
        logic [3:0][23:0] w;
        logic [3:0][17:0] v;
    } vec_t;

    vec_t tbl[4];
    logic [3:0][17:0] ref_v;
    logic [3:0][23:0] wa, wb;

    initial begin
        tbl[0].w = {24'h000004, 24'h000003, 24'h000002, 24'h000001};
        tbl[0].v = {18'd0, 18'd0, 18'd0, 18'd0};
        tbl[1].w = {24'h100010, 24'h10000C, 24'h100008, 24'h100004};
        tbl[1].v = {18'd4, 18'd3, 18'd2, 18'd1};
        tbl[2].w = {24'h100000, 24'h1FFFFC, 24'h200008, 24'h900008};
        tbl[2].v = {18'd0, 18'h3FFFF, 18'd2, 18'd1};
        tbl[3].w = {24'h100003, 24'h000000, 24'h155554, 24'h1AAAA8};
        tbl[3].v = {18'd0, 18'h3FFFF, 18'h15555, 18'h2AAAA};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_sclk",  32'(sclk),  32'd1);
        check("rst_syncn", 32'(syncn), 32'd1);
        check("rst_ldacn", 32'(ldacn), 32'd1);
        check("rst_sdo",   32'({sz2, sz, sy, sx}), 32'd0);
        check("rst_busy3", 32'(busy3), 32'd0);
        check("rst_vout",  32'(|vv), 32'd0);
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 4; i++) begin
            run(tbl[i].w, '0, -1, 0);
            check($sformatf("tbl%0d_timeout", i), 32'(timed_out), 32'd0);
            check($sformatf("tbl%0d_frames", i), frames, 32'd1);
            check($sformatf("tbl%0d_busy", i), busy_cyc, 32'd52);
            check($sformatf("tbl%0d_syncn", i), syncn_cyc, 32'd48);
            check($sformatf("tbl%0d_ldac", i), ldac_cyc, 32'd2);
            for (int c = 0; c < 4; c++) begin
                check($sformatf("tbl%0d_bits_ch%0d", i, c), 32'(cap[0][c]), 32'(tbl[i].w[c]));
                check($sformatf("tbl%0d_vout_ch%0d", i, c), 32'(vv[c]), 32'(tbl[i].v[c]));
            end
        end

        // Random words against the reference rule
        ref_v = tbl[3].v;
        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < 4; c++) begin
                wa[c] = 24'($urandom);
                if ($urandom_range(0, 1) == 1) wa[c][23:20] = 4'h1;
                ref_v[c] = ref_next(wa[c], ref_v[c]);
            end
            run(wa, '0, -1, 0);
            check($sformatf("rnd%0d_frames", i), frames, 32'd1);
            for (int c = 0; c < 4; c++) begin
                check($sformatf("rnd%0d_bits_ch%0d", i, c), 32'(cap[0][c]), 32'(wa[c]));
                check($sformatf("rnd%0d_vout_ch%0d", i, c), 32'(vv[c]), 32'(ref_v[c]));
            end
        end

        // valid during a transfer is ignored
        wa = {24'h100020, 24'h10001C, 24'h100018, 24'h100014};
        wb = {24'h1FFFFC, 24'h1FFFFC, 24'h1FFFFC, 24'h1FFFFC};
        run(wa, wb, 10, 0);
        check("ign_frames", frames, 32'd1);
        check("ign_busy", busy_cyc, 32'd52);
        for (int c = 0; c < 4; c++) check($sformatf("ign_bits_ch%0d", c), 32'(cap[0][c]), 32'(wa[c]));
        check("ign_vout", 32'(vv), 32'({18'd8, 18'd7, 18'd6, 18'd5}));

        // Back-to-back: valid in the idle cycle after LDAC is accepted
        wa = {24'h100100, 24'h1000C0, 24'h100080, 24'h100040};
        wb = {24'h101000, 24'h100C00, 24'h100800, 24'h100400};
        run(wa, wb, -1, 1);
        check("b2b_timeout", 32'(timed_out), 32'd0);
        check("b2b_frames", frames, 32'd2);
        check("b2b_busy", busy_cyc, 32'd104);
        check("b2b_gap", gap_cyc, 32'd1);
        check("b2b_ldac_pulses", ldac_pulses, 32'd2);
        check("b2b_ldac_to_frame", frame2_start - ldac1_end, 32'd1);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("b2b_f1_ch%0d", c), 32'(cap[0][c]), 32'(wa[c]));
            check($sformatf("b2b_f2_ch%0d", c), 32'(cap[1][c]), 32'(wb[c]));
        end
        check("b2b_vout", 32'(vv[0]), 32'h100);
        check("b2b_vout_z2", 32'(vv[3]), 32'h400);

        // Reset in cycle 20 of SHIFT aborts with no LDAC pulse
        begin
            int low_ldac = 0;
            @(negedge clk);
            {dz2, dz, dy, dx} = {24'h13FFFC, 24'h13FFFC, 24'h13FFFC, 24'h13FFFC};
            valid = 1'b1;
            @(negedge clk);
            valid = 1'b0;
            repeat (19) @(negedge clk);
            check("abort_pre_syncn", 32'(syncn), 32'd0);
            rst = 1'b1;
            #1;
            check("abort_syncn", 32'(syncn), 32'd1);
            check("abort_sclk", 32'(sclk), 32'd1);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_sdo", 32'({sz2, sz, sy, sx}), 32'd0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (!ldacn) low_ldac++;
            end
            check("abort_no_ldac", low_ldac, 32'd0);
            check("abort_idle", 32'(busy), 32'd0);
            check("abort_vout_x", 32'(vv[0]), 32'h100);
            check("abort_vout_z2", 32'(vv[3]), 32'h400);
        end

        // SCLK_HALF=3 timing
        begin
            logic [3:0][23:0] c3 = '0;
            logic p_sync = 1'b1, p_sclk = 1'b1, lvl = 1'b1;
            int run_len = 0, low_cnt = 0;
            int hi_n = 0, lo_n = 0, hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;
            wa = {24'h0F0F0F, 24'hABCDEF, 24'h654321, 24'h123456};
            @(negedge clk);
            {dz2, dz, dy, dx} = wa;
            valid3 = 1'b1;
            @(negedge clk);
            valid3 = 1'b0;
            for (int k = 0; k < 200; k++) begin
                if (!syncn3) begin
                    low_cnt++;
                    if (p_sync) begin
                        lvl = sclk3;
                        run_len = 1;
                    end else if (sclk3 == lvl) begin
                        run_len++;
                    end else begin
                        if (lvl) begin hi_n++; hi_min = (run_len < hi_min) ? run_len : hi_min; hi_max = (run_len > hi_max) ? run_len : hi_max; end
                        else     begin lo_n++; lo_min = (run_len < lo_min) ? run_len : lo_min; lo_max = (run_len > lo_max) ? run_len : lo_max; end
                        lvl = sclk3;
                        run_len = 1;
                    end
                    if (p_sclk && !sclk3) begin
                        c3[0] = {c3[0][22:0], sx3};
                        c3[1] = {c3[1][22:0], sy3};
                        c3[2] = {c3[2][22:0], sz3};
                        c3[3] = {c3[3][22:0], sz23};
                    end
                end else if (!p_sync) begin
                    if (lvl) begin hi_n++; hi_min = (run_len < hi_min) ? run_len : hi_min; hi_max = (run_len > hi_max) ? run_len : hi_max; end
                    else     begin lo_n++; lo_min = (run_len < lo_min) ? run_len : lo_min; lo_max = (run_len > lo_max) ? run_len : lo_max; end
                end
                p_sync = syncn3;
                p_sclk = sclk3;
                @(negedge clk);
            end
            check("s3_done", 32'(busy3), 32'd0);
            check("s3_syncn_low", low_cnt, 32'd144);
            check("s3_hi_runs", hi_n, 32'd24);
            check("s3_lo_runs", lo_n, 32'd24);
            check("s3_hi_min", hi_min, 32'd3);
            check("s3_hi_max", hi_max, 32'd3);
            check("s3_lo_min", lo_min, 32'd3);
            check("s3_lo_max", lo_max, 32'd3);
            for (int c = 0; c < 4; c++) check($sformatf("s3_bits_ch%0d", c), 32'(c3[c]), 32'(wa[c]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
